// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared helpers and status type for the parametrised sync FIFO
package fifo_pkg;

  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_if.sv
// rtl/fifo_if.sv - port bundle of sync_fifo_param for design and bench sides
interface fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic rst
);
  logic                   wr_en;
  logic [WIDTH-1:0]       wr_data;
  logic                   rd_en;
  logic [WIDTH-1:0]       rd_data;
  logic                   rd_valid;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   underflow;

  modport des (
    input  clk, rst, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport tb (
    input  clk, rst, rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow,
    output wr_en, wr_data, rd_en
  );
endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - WIDTH x DEPTH simple dual-port RAM, synchronous write, asynchronous read
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with occupancy counter,
// threshold flags, overflow/underflow pulses and selectable first-word-fall-through
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int AW = calc_aw(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must not exceed DEPTH");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q, unf_q;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rd_data;
  fifo_status_t     status;

  // All flags derive from registered state, so they only move on clk or rst.
  always_comb begin
    status.full         = (cnt == FULL_CNT);
    status.empty        = (cnt == '0);
    status.almost_full  = (cnt >= AF_CNT);
    status.almost_empty = (cnt <= AE_CNT);
    status.overflow     = ovf_q;
    status.underflow    = unf_q;
  end

  assign wr_acc = wr_en & ~status.full;
  assign rd_acc = rd_en & ~status.empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      ovf_q <= wr_en & status.full;
      unf_q <= rd_en & status.empty;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = mem_rd_data;
    assign rd_valid = ~status.empty;
  end else begin : g_reg_rd
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    // rd_data keeps the last popped word when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_rd_data;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = cnt;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized and directed bench for sync_fifo_param, registered and FWFT builds
module tb_sync_fifo_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, wr_en_f, rd_en_f;
  logic [7:0] wr_data, wr_data_f;
  logic [7:0] rd_data, rd_data_f;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic       rd_valid_f, full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
  logic [4:0] count, count_f;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] qf[$];
  logic [7:0] exp_rd;
  bit         exp_rv, exp_ovf, exp_unf, exp_ovf_f, exp_unf_f;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en_f), .wr_data(wr_data_f), .rd_en(rd_en_f),
    .rd_data(rd_data_f), .rd_valid(rd_valid_f), .full(full_f), .empty(empty_f),
    .almost_full(almost_full_f), .almost_empty(almost_empty_f), .count(count_f),
    .overflow(overflow_f), .underflow(underflow_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n, nf;
    n  = q.size();
    nf = qf.size();
    check({tag, " count"},    32'(count),        32'(n));
    check({tag, " full"},     32'(full),         32'(n == DEPTH));
    check({tag, " empty"},    32'(empty),        32'(n == 0));
    check({tag, " afull"},    32'(almost_full),  32'(n >= AF));
    check({tag, " aempty"},   32'(almost_empty), 32'(n <= AE));
    check({tag, " overflow"}, 32'(overflow),     32'(exp_ovf));
    check({tag, " underflow"},32'(underflow),    32'(exp_unf));
    check({tag, " rd_valid"}, 32'(rd_valid),     32'(exp_rv));
    check({tag, " rd_data"},  32'(rd_data),      32'(exp_rd));
    check({tag, " f.count"},    32'(count_f),        32'(nf));
    check({tag, " f.full"},     32'(full_f),         32'(nf == DEPTH));
    check({tag, " f.empty"},    32'(empty_f),        32'(nf == 0));
    check({tag, " f.afull"},    32'(almost_full_f),  32'(nf >= AF));
    check({tag, " f.aempty"},   32'(almost_empty_f), 32'(nf <= AE));
    check({tag, " f.overflow"}, 32'(overflow_f),     32'(exp_ovf_f));
    check({tag, " f.underflow"},32'(underflow_f),    32'(exp_unf_f));
    check({tag, " f.rd_valid"}, 32'(rd_valid_f),     32'(nf > 0));
    if (nf > 0) check({tag, " f.rd_data"}, 32'(rd_data_f), 32'(qf[0]));
  endtask

  // Drive one cycle on both FIFOs, advance the queue models, then compare.
  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit wf, input logic [7:0] df, input bit rf, input string tag);
    int n, nf;
    wr_en = w; wr_data = d; rd_en = r;
    wr_en_f = wf; wr_data_f = df; rd_en_f = rf;
    @(posedge clk);
    n  = q.size();
    nf = qf.size();
    exp_ovf = w && (n == DEPTH);
    exp_unf = r && (n == 0);
    exp_rv  = r && (n > 0);
    if (exp_rv) exp_rd = q.pop_front();
    if (w && n < DEPTH) q.push_back(d);
    exp_ovf_f = wf && (nf == DEPTH);
    exp_unf_f = rf && (nf == 0);
    if (rf && nf > 0) void'(qf.pop_front());
    if (wf && nf < DEPTH) qf.push_back(df);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    wr_en = 0; rd_en = 0; wr_en_f = 0; rd_en_f = 0;
    #1;
    q.delete(); qf.delete();
    exp_rd = '0; exp_rv = 0; exp_ovf = 0; exp_unf = 0; exp_ovf_f = 0; exp_unf_f = 0;
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 0; rd_en = 0; wr_en_f = 0; rd_en_f = 0; wr_data = '0; wr_data_f = '0;
    @(negedge clk);
    do_reset("por");

    // Reset in the middle of traffic with five entries held and a nonzero rd_data.
    for (int i = 0; i < 6; i++) step(1, 8'h60 + 8'(i), 0, 1, 8'h70 + 8'(i), 0, "pre_rst_wr");
    step(0, 8'h00, 1, 0, 8'h00, 0, "pre_rst_rd");
    check("pre_rst count", 32'(count), 32'd5);
    do_reset("mid_rst");
    step(0, 8'h00, 1, 0, 8'h00, 1, "rd_after_rst");
    check("rd_after_rst underflow", 32'(underflow), 32'd1);

    // Fill to full, then one dropped write.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 8'h00, 0, "fill");
    check("fill full", 32'(full), 32'd1);
    step(1, 8'hAA, 0, 0, 8'h00, 0, "overflow_wr");
    check("overflow pulse", 32'(overflow), 32'd1);
    step(0, 8'h00, 0, 0, 8'h00, 0, "overflow_clear");

    // Drain, then one read too many.
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 8'h00, 0, "drain");
    check("drain last", 32'(rd_data), 32'h0F);
    step(0, 8'h00, 1, 0, 8'h00, 0, "underflow_rd");
    check("underflow pulse", 32'(underflow), 32'd1);

    // Half full, then steady simultaneous traffic across pointer wrap.
    for (int i = 0; i < 8; i++) step(1, 8'h80 + 8'(i), 0, 0, 8'h00, 0, "half");
    for (int i = 0; i < 40; i++) step(1, 8'h88 + 8'(i), 1, 0, 8'h00, 0, "steady");
    check("steady count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 8'h00, 0, "steady_drain");

    // Simultaneous on empty, then simultaneous on full.
    step(1, 8'h5A, 1, 0, 8'h00, 0, "both_empty");
    check("both_empty underflow", 32'(underflow), 32'd1);
    check("both_empty count", 32'(count), 32'd1);
    for (int i = 0; i < 15; i++) step(1, 8'hC0 + 8'(i), 0, 0, 8'h00, 0, "refill");
    step(1, 8'hEE, 1, 0, 8'h00, 0, "both_full");
    check("both_full head", 32'(rd_data), 32'h5A);
    check("both_full count", 32'(count), 32'd15);
    check("both_full overflow", 32'(overflow), 32'd1);

    // FWFT: a word written to an empty FIFO shows up the next cycle.
    step(0, 8'h00, 0, 1, 8'h3C, 0, "fwft_wr");
    check("fwft rd_valid", 32'(rd_valid_f), 32'd1);
    check("fwft rd_data", 32'(rd_data_f), 32'h3C);
    step(0, 8'h00, 0, 0, 8'h00, 1, "fwft_pop");
    check("fwft empty", 32'(empty_f), 32'd1);

    // Random traffic in phases biased toward filling and draining.
    for (int ph = 0; ph < 8; ph++) begin
      int pw, pr;
      pw = (ph % 2 == 0) ? 75 : 30;
      pr = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 60; i++)
        step(($urandom % 100) < pw, 8'($urandom), ($urandom % 100) < pr,
             ($urandom % 100) < pw, 8'($urandom), ($urandom % 100) < pr, "rand");
    end
    do_reset("final_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
